// File: rtl/bp_pkg.sv
// Shared types for the branch resolve path: 2-bit saturating counter states,
// in-flight prediction entry layout and the counter training helpers.
package bp_pkg;

  localparam int BP_IDXW = 6;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } sat_state_t;

  typedef struct packed {
    logic               taken;
    logic [BP_IDXW-1:0] idx;
    sat_state_t         state;
  } bp_entry_t;

  localparam int BP_EW = $bits(bp_entry_t);

  function automatic sat_state_t sat_inc(input sat_state_t s);
    return (s == ST) ? ST : sat_state_t'(s + 2'd1);
  endfunction

  function automatic sat_state_t sat_dec(input sat_state_t s);
    return (s == SNT) ? SNT : sat_state_t'(s - 2'd1);
  endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// In-flight prediction queue; head is visible combinationally, push/pop take effect on the edge.
// full is derived from the registered count only; clear wins over push and pop.
module bp_pred_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [BP_EW-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [BP_EW-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [BP_EW-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks EX branch outcomes against queued fetch predictions; Mispredict/RedirectPC are same-cycle,
// the counter write-back lands one cycle later. StallF holds IF while the queue is full.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int IDXW  = BP_IDXW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pred_valid,
  input  logic            pred_taken,
  input  logic [IDXW-1:0] pred_idx,
  input  logic [1:0]      pred_state,
  output logic            StallF,
  input  logic            Branch,
  input  logic            Zero,
  input  logic [XLEN-1:0] BranchTarget,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic            Mispredict,
  output logic [XLEN-1:0] RedirectPC,
  output logic            upd_valid,
  output logic [IDXW-1:0] upd_idx,
  output logic [1:0]      upd_state,
  output logic            underflow,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  bp_entry_t        wentry;
  bp_entry_t        hentry;
  logic [BP_EW-1:0] head_bits;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;

  assign wentry.taken = pred_taken;
  assign wentry.idx   = pred_idx;
  assign wentry.state = sat_state_t'(pred_state);
  assign hentry       = bp_entry_t'(head_bits);

  assign pop        = Branch && !empty;
  assign Mispredict = pop && (Zero != hentry.taken);
  assign RedirectPC = Zero ? BranchTarget : PCPlus4E;
  assign StallF     = full;
  // A pop frees the slot this cycle, so a push while full is still safe alongside it.
  // Everything behind a mispredicted head is wrong-path, including a same-cycle push.
  assign push       = pred_valid && (!full || pop) && !Mispredict;

  bp_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (Mispredict),
    .wdata (wentry),
    .full  (full),
    .empty (empty),
    .head  (head_bits)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid   <= 1'b0;
      upd_idx     <= '0;
      upd_state   <= SNT;
      underflow   <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      upd_valid <= pop;
      if (pop) begin
        upd_idx   <= hentry.idx;
        upd_state <= Zero ? sat_inc(hentry.state) : sat_dec(hentry.state);
        if (branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
      end
      if (Mispredict && mispred_cnt != 32'hFFFF_FFFF) mispred_cnt <= mispred_cnt + 32'd1;
      if (Branch && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and random stimulus for branch_resolve_unit checked against a queue-based model.
module tb_branch_resolve_unit;
  import bp_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int IDXW  = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            pred_valid, pred_taken;
  logic [IDXW-1:0] pred_idx;
  logic [1:0]      pred_state;
  logic            StallF;
  logic            Branch, Zero;
  logic [XLEN-1:0] BranchTarget, PCPlus4E;
  logic            Mispredict;
  logic [XLEN-1:0] RedirectPC;
  logic            upd_valid;
  logic [IDXW-1:0] upd_idx;
  logic [1:0]      upd_state;
  logic            underflow;
  logic [31:0]     branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_state(pred_state),
    .StallF(StallF),
    .Branch(Branch), .Zero(Zero), .BranchTarget(BranchTarget), .PCPlus4E(PCPlus4E),
    .Mispredict(Mispredict), .RedirectPC(RedirectPC),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_state(upd_state),
    .underflow(underflow), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    int taken;
    int idx;
    int state;
  } ment_t;

  ment_t       q[$];
  int          checks = 0;
  int          failures = 0;
  int          m_uv = 0, m_ui = 0, m_us = 0, m_uf = 0;
  int unsigned m_bc = 0, m_mc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check same-cycle outputs, advance model, check registered outputs.
  task automatic step(input logic pv, input logic pt, input int pi, input int ps,
                      input logic br, input logic z, input logic [31:0] tgt,
                      input logic [31:0] pc4, input logic rst);
    int    sz;
    bit    do_pop;
    bit    mis;
    ment_t h;
    ment_t n;
    reset = rst; pred_valid = pv; pred_taken = pt;
    pred_idx = IDXW'(pi); pred_state = 2'(ps);
    Branch = br; Zero = z; BranchTarget = tgt; PCPlus4E = pc4;
    #1;
    sz     = q.size();
    do_pop = br && (sz > 0);
    mis    = do_pop && (int'(z) != q[0].taken);
    if (!rst) begin
      chk("stallf_pre", 64'(StallF), 64'(sz == DEPTH));
      chk("mispredict", 64'(Mispredict), 64'(mis));
      if (mis) chk("redirect", 64'(RedirectPC), 64'(z ? tgt : pc4));
    end
    if (rst) begin
      q.delete();
      m_uv = 0; m_ui = 0; m_us = 0; m_uf = 0; m_bc = 0; m_mc = 0;
    end else begin
      m_uv = 0;
      if (br && sz == 0) m_uf = 1;
      if (do_pop) begin
        h = q.pop_front();
        m_uv = 1;
        m_ui = h.idx;
        if (z) m_us = (h.state == 3) ? 3 : h.state + 1;
        else   m_us = (h.state == 0) ? 0 : h.state - 1;
        if (m_bc != 32'hFFFF_FFFF) m_bc++;
      end
      if (mis) begin
        q.delete();
        if (m_mc != 32'hFFFF_FFFF) m_mc++;
      end else if (pv && (sz < DEPTH || do_pop)) begin
        n.taken = int'(pt); n.idx = pi; n.state = ps;
        q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
    chk("upd_valid", 64'(upd_valid), 64'(m_uv));
    chk("upd_idx", 64'(upd_idx), 64'(m_ui));
    chk("upd_state", 64'(upd_state), 64'(m_us));
    chk("underflow", 64'(underflow), 64'(m_uf));
    chk("branch_cnt", 64'(branch_cnt), 64'(m_bc));
    chk("mispred_cnt", 64'(mispred_cnt), 64'(m_mc));
    chk("stallf", 64'(StallF), 64'(q.size() == DEPTH));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic push_pred(input logic t, input int i, input int s);
    step(1, t, i, s, 0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic resolve(input logic z, input logic [31:0] tgt, input logic [31:0] pc4);
    step(0, 0, 0, 0, 1, z, tgt, pc4, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    chk("rst_upd_state", 64'(upd_state), 64'(SNT));
    chk("rst_cnt", 64'(branch_cnt), 64'd0);

    // Correct not-taken prediction trains WNT down to SNT.
    push_pred(0, 5, 1);
    resolve(0, 32'h200, 32'h84);
    chk("t1_upd_valid", 64'(upd_valid), 64'd1);
    chk("t1_upd_idx", 64'(upd_idx), 64'd5);
    chk("t1_upd_state", 64'(upd_state), 64'(SNT));
    chk("t1_branch_cnt", 64'(branch_cnt), 64'd1);
    idle();
    chk("t1_one_shot", 64'(upd_valid), 64'd0);

    // Predicted taken, actually not taken.
    push_pred(1, 3, 2);
    BranchTarget = 32'h300; PCPlus4E = 32'h104; Branch = 1'b1; Zero = 1'b0;
    #1;
    chk("t2_mispredict", 64'(Mispredict), 64'd1);
    chk("t2_redirect", 64'(RedirectPC), 64'h104);
    resolve(0, 32'h300, 32'h104);
    chk("t2_upd_state", 64'(upd_state), 64'(WNT));
    chk("t2_mispred_cnt", 64'(mispred_cnt), 64'd1);

    // Fill, then simultaneous pop and push while full.
    for (int i = 0; i < DEPTH; i++) push_pred(1, 10 + i, 2);
    chk("t3_full", 64'(StallF), 64'd1);
    step(1, 1, 14, 2, 1, 1, 32'h400, 32'h0, 0);
    chk("t3_still_full", 64'(StallF), 64'd1);
    chk("t3_popped_idx", 64'(upd_idx), 64'd10);
    resolve(0, 32'h0, 32'h500);
    chk("t3_flushed", 64'(StallF), 64'd0);

    // Mispredict with a same-cycle push empties the queue; next Branch underflows.
    for (int i = 0; i < 3; i++) push_pred(0, 20 + i, 1);
    step(1, 0, 23, 1, 1, 1, 32'h600, 32'h0, 0);
    chk("t4_stallf", 64'(StallF), 64'd0);
    resolve(1, 32'h700, 32'h0);
    chk("t4_underflow", 64'(underflow), 64'd1);
    chk("t4_no_update", 64'(upd_valid), 64'd0);

    // Counter saturation at both ends.
    push_pred(1, 7, 3);
    resolve(1, 32'h800, 32'h0);
    chk("t5_sat_st", 64'(upd_state), 64'(ST));
    push_pred(0, 8, 0);
    resolve(0, 32'h0, 32'h900);
    chk("t5_sat_snt", 64'(upd_state), 64'(SNT));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           $urandom, $urandom, 0);
    end

    // Reset while entries are queued and a Branch is resolving.
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    push_pred(1, 30, 2);
    push_pred(0, 31, 1);
    step(0, 0, 0, 0, 1, 1, 32'hA00, 32'h0, 1);
    chk("t6_upd_valid", 64'(upd_valid), 64'd0);
    chk("t6_branch_cnt", 64'(branch_cnt), 64'd0);
    chk("t6_mispred_cnt", 64'(mispred_cnt), 64'd0);
    resolve(1, 32'hB00, 32'h0);
    chk("t6_empty", 64'(underflow), 64'd1);
    chk("t6_no_pop", 64'(branch_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
